fetch_unit: RTL and testbench

- Instruction-fetch front end feeding the IF/ID register of the 5-stage RV32 pipeline.
- Issues sequential word requests to a variable-latency instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned instructions, tagged with PC, in a small prefetch queue and presents them to decode under a valid/ready handshake.
- Handles branch/jump redirects by flushing the queue and discarding in-flight stale responses.

---
 rtl/fetch_unit.sv | 174 +++++++++++++++++
 tb/tb_fetch_unit.sv | 496 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch front end for the 5-stage RV32 pipeline. Issues sequential
// word fetches to a variable-latency instruction memory, buffers the returned
// instructions (tagged with their PC) in a small circular prefetch queue, and
// hands them to decode under a valid/ready handshake. A redirect from EX
// flushes the queue and marks every in-flight response as stale.
//
// Ports
//   clk             in   clock, rising edge
//   reset           in   synchronous active-high reset
//   imem_req_valid  out  fetch request valid
//   imem_req_ready  in   memory accepts the request this cycle
//   imem_req_addr   out  word-aligned fetch address
//   imem_resp_valid in   in-order response valid (one per accepted request)
//   imem_resp_data  in   fetched instruction
//   redirect        in   taken branch/jump from EX, flushes the front end
//   redirect_pc     in   new fetch target, bits [1:0] ignored
//   id_ready        in   decode can accept the head instruction
//   id_valid        out  queue head valid
//   id_instr        out  head instruction, NOP_INSTR when id_valid is low
//   id_pc           out  PC of the head instruction
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter int unsigned DEPTH     = 4,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        id_ready,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(DEPTH);

   // State
   logic [31:0]      r_fetch_pc;
   logic [31:0]      r_head_pc;
   logic [31:0]      r_queue [DEPTH];
   logic [PTR_W-1:0] r_rd;
   logic [PTR_W-1:0] r_wr;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_outstanding;
   logic [CNT_W-1:0] r_discard;

   // Next state
   logic [31:0]      w_fetch_pc_d;
   logic [31:0]      w_head_pc_d;
   logic [PTR_W-1:0] w_rd_d;
   logic [PTR_W-1:0] w_wr_d;
   logic [CNT_W-1:0] w_count_d;
   logic [CNT_W-1:0] w_outstanding_d;
   logic [CNT_W-1:0] w_discard_d;

   // Handshake decode
   logic             w_accept;
   logic             w_resp;
   logic             w_push;
   logic             w_drop;
   logic             w_pop;
   logic [CNT_W:0]   w_credit_used;
   logic [CNT_W-1:0] w_resp_cnt;
   logic [31:0]      w_redirect_target;
   logic             w_unused_redirect_lsbs;

   assign w_redirect_target      = {redirect_pc[31:2], 2'b00};
   assign w_unused_redirect_lsbs = ^redirect_pc[1:0];

   // Buffered plus outstanding entries may never exceed the queue size, so a
   // response always has a free slot to land in.
   assign w_credit_used = {1'b0, r_count} + {1'b0, r_outstanding};

   assign imem_req_valid = !reset && !redirect && (w_credit_used < DEPTH_LIM);
   assign imem_req_addr  = r_fetch_pc;
   assign w_accept       = imem_req_valid && imem_req_ready;

   // A response with nothing outstanding is a protocol violation; ignore it.
   assign w_resp     = imem_resp_valid && (r_outstanding != '0);
   assign w_drop     = w_resp && (r_discard != '0);
   assign w_push     = w_resp && (r_discard == '0) && !redirect;
   assign w_resp_cnt = {{(CNT_W - 1){1'b0}}, w_resp};

   assign id_valid = !reset && (r_count != '0);
   assign id_instr = id_valid ? r_queue[r_rd] : NOP_INSTR;
   assign id_pc    = reset ? RESET_PC : r_head_pc;
   assign w_pop    = id_valid && id_ready;

   always_comb begin
      w_fetch_pc_d    = r_fetch_pc;
      w_head_pc_d     = r_head_pc;
      w_rd_d          = r_rd;
      w_wr_d          = r_wr;
      w_count_d       = r_count;
      w_outstanding_d = r_outstanding;
      w_discard_d     = r_discard;

      if (redirect) begin
         // Flush: everything still in flight becomes stale, except a response
         // landing this very cycle, which is dropped here and now.
         w_fetch_pc_d    = w_redirect_target;
         w_head_pc_d     = w_redirect_target;
         w_rd_d          = '0;
         w_wr_d          = '0;
         w_count_d       = '0;
         w_outstanding_d = r_outstanding - w_resp_cnt;
         w_discard_d     = r_outstanding - w_resp_cnt;
      end else begin
         if (w_accept) begin
            w_fetch_pc_d = r_fetch_pc + 32'd4;
         end
         if (w_pop) begin
            w_head_pc_d = r_head_pc + 32'd4;
            w_rd_d      = r_rd + PTR_W'(1);
         end
         if (w_push) begin
            w_wr_d = r_wr + PTR_W'(1);
         end
         if (w_accept && !w_resp) begin
            w_outstanding_d = r_outstanding + CNT_W'(1);
         end else if (!w_accept && w_resp) begin
            w_outstanding_d = r_outstanding - CNT_W'(1);
         end
         if (w_drop) begin
            w_discard_d = r_discard - CNT_W'(1);
         end
         if (w_push && !w_pop) begin
            w_count_d = r_count + CNT_W'(1);
         end else if (w_pop && !w_push) begin
            w_count_d = r_count - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fetch_pc    <= RESET_PC;
         r_head_pc     <= RESET_PC;
         r_rd          <= '0;
         r_wr          <= '0;
         r_count       <= '0;
         r_outstanding <= '0;
         r_discard     <= '0;
      end else begin
         r_fetch_pc    <= w_fetch_pc_d;
         r_head_pc     <= w_head_pc_d;
         r_rd          <= w_rd_d;
         r_wr          <= w_wr_d;
         r_count       <= w_count_d;
         r_outstanding <= w_outstanding_d;
         r_discard     <= w_discard_d;
      end
   end

   // Queue storage needs no reset: entries are only read while counted valid.
   always_ff @(posedge clk) begin
      if (!reset && w_push) begin
         r_queue[r_wr] <= imem_resp_data;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        id_ready;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;

   int vectors;
   int miscompares;
   int cyc;
   int lat;

   logic [31:0] mem_addr_q [$];
   int          mem_due_q  [$];
   logic [31:0] req_log    [$];
   logic [31:0] pop_pc     [$];
   logic [31:0] pop_ins    [$];

   fetch_unit #(
      .DEPTH     (DEPTH),
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (NOP)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .id_ready        (id_ready),
      .id_valid        (id_valid),
      .id_instr        (id_instr),
      .id_pc           (id_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {a[19:0], 12'h093};
   endfunction

   // Credit invariant and push-into-full-queue detection.
   always @(negedge clk) begin
      if (!reset) begin
         if (int'(dut.r_count) + int'(dut.r_outstanding) > DEPTH) begin
            miscompares++;
            $display("FAIL credit: count+outstanding=%0d limit %0d",
                     int'(dut.r_count) + int'(dut.r_outstanding), DEPTH);
         end
         if (int'(dut.r_discard) > int'(dut.r_outstanding)) begin
            miscompares++;
            $display("FAIL discard_bound: discard=%0d outstanding=%0d",
                     dut.r_discard, dut.r_outstanding);
         end
         if (imem_resp_valid && !redirect && dut.r_outstanding != 0 && dut.r_discard == 0
             && int'(dut.r_count) == DEPTH) begin
            miscompares++;
            $display("FAIL overflow: push with count=%0d required < %0d", dut.r_count, DEPTH);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required finish before 200000");
      $fatal(1, "timeout");
   end

   // One clock: log accepted requests and pops, then model the memory.
   task automatic tick();
      logic [31:0] a;
      int          d;
      @(negedge clk);
      if (imem_resp_valid && mem_addr_q.size() > 0) begin
         a = mem_addr_q.pop_front();
         d = mem_due_q.pop_front();
      end
      if (imem_req_valid && imem_req_ready) begin
         req_log.push_back(imem_req_addr);
         mem_addr_q.push_back(imem_req_addr);
         mem_due_q.push_back(cyc + lat);
      end
      if (id_valid && id_ready) begin
         pop_pc.push_back(id_pc);
         pop_ins.push_back(id_instr);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
         mem_addr_q.delete();
         mem_due_q.delete();
      end
      if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = instr_of(mem_addr_q[0]);
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = 32'hDEAD_BEEF;
      end
   endtask

   task automatic clear_logs();
      req_log.delete();
      pop_pc.delete();
      pop_ins.delete();
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      redirect = 1'b0;
      tick();
      reset = 1'b0;
      #1;
      clear_logs();
   endtask

   task automatic test_reset();
      lat = 1; imem_req_ready = 1'b1; id_ready = 1'b1;
      reset = 1'b1;
      tick();
      tick();
      #1;
      vectors++;
      if (imem_req_valid !== 1'b0) begin
         miscompares++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid);
      end
      vectors++;
      if (id_valid !== 1'b0) begin
         miscompares++; $display("FAIL reset_id_valid: got %b want 0", id_valid);
      end
      vectors++;
      if (id_instr !== NOP) begin
         miscompares++; $display("FAIL reset_id_instr: got %h want %h", id_instr, NOP);
      end
      vectors++;
      if (id_pc !== 32'h0) begin
         miscompares++; $display("FAIL reset_id_pc: got %h want 0", id_pc);
      end
      reset = 1'b0;
      #1;
      clear_logs();
      vectors++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
         miscompares++;
         $display("FAIL release_req: got valid=%b addr=%h want 1/0", imem_req_valid, imem_req_addr);
      end
   endtask

   task automatic test_sequential();
      lat = 1; imem_req_ready = 1'b1; id_ready = 1'b1;
      do_reset();
      vectors++;
      if (id_valid !== 1'b0) begin
         miscompares++; $display("FAIL seq_c0_valid: got %b want 0", id_valid);
      end
      tick();
      vectors++;
      if (id_valid !== 1'b0 || imem_req_addr !== 32'h4) begin
         miscompares++;
         $display("FAIL seq_c1: got valid=%b addr=%h want 0/4", id_valid, imem_req_addr);
      end
      tick();
      vectors++;
      if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== instr_of(32'h0)) begin
         miscompares++;
         $display("FAIL seq_first: got valid=%b pc=%h instr=%h want 1/0/%h",
                  id_valid, id_pc, id_instr, instr_of(32'h0));
      end
      repeat (10) tick();
      vectors++;
      if (req_log.size() != 12 || pop_pc.size() != 10) begin
         miscompares++;
         $display("FAIL seq_counts: got req=%0d pop=%0d want 12/10", req_log.size(), pop_pc.size());
      end else begin
         for (int i = 0; i < 12; i++) begin
            vectors++;
            if (req_log[i] !== 32'(4 * i)) begin
               miscompares++; $display("FAIL seq_req[%0d]: got %h want %h", i, req_log[i], 4 * i);
            end
         end
         for (int i = 0; i < 10; i++) begin
            vectors++;
            if (pop_pc[i] !== 32'(4 * i) || pop_ins[i] !== instr_of(32'(4 * i))) begin
               miscompares++;
               $display("FAIL seq_pop[%0d]: got pc=%h instr=%h want %h/%h", i, pop_pc[i],
                        pop_ins[i], 4 * i, instr_of(32'(4 * i)));
            end
         end
      end
   endtask

   task automatic test_stall();
      lat = 1; imem_req_ready = 1'b1; id_ready = 1'b0;
      do_reset();
      repeat (10) tick();
      vectors++;
      if (req_log.size() != 4) begin
         miscompares++; $display("FAIL stall_req_count: got %0d want 4", req_log.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            vectors++;
            if (req_log[i] !== 32'(4 * i)) begin
               miscompares++; $display("FAIL stall_req[%0d]: got %h want %h", i, req_log[i], 4 * i);
            end
         end
      end
      vectors++;
      if (imem_req_valid !== 1'b0 || id_valid !== 1'b1 || id_pc !== 32'h0) begin
         miscompares++;
         $display("FAIL stall_full: got req_valid=%b id_valid=%b pc=%h want 0/1/0",
                  imem_req_valid, id_valid, id_pc);
      end
      id_ready = 1'b1;
      repeat (8) tick();
      vectors++;
      if (pop_pc.size() < 4 || req_log.size() < 5) begin
         miscompares++;
         $display("FAIL stall_drain: got pops=%0d reqs=%0d want >=4/>=5", pop_pc.size(),
                  req_log.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            vectors++;
            if (pop_pc[i] !== 32'(4 * i)) begin
               miscompares++; $display("FAIL stall_pop[%0d]: got %h want %h", i, pop_pc[i], 4 * i);
            end
         end
         vectors++;
         if (req_log[4] !== 32'h10) begin
            miscompares++; $display("FAIL stall_resume: got %h want 10", req_log[4]);
         end
      end
   endtask

   task automatic test_redirect_inflight();
      int n;
      lat = 3; imem_req_ready = 1'b0; id_ready = 1'b1;
      do_reset();
      redirect = 1'b1; redirect_pc = 32'h22;
      tick();
      redirect = 1'b0; imem_req_ready = 1'b1;
      tick();
      tick();
      imem_req_ready = 1'b0;
      redirect = 1'b1; redirect_pc = 32'h104; imem_req_ready = 1'b1;
      #1;
      vectors++;
      if (imem_req_valid !== 1'b0) begin
         miscompares++; $display("FAIL rdr_no_req: got %b want 0", imem_req_valid);
      end
      tick();
      redirect = 1'b0;
      #1;
      vectors++;
      if (dut.r_discard != 2 || dut.r_outstanding != 2 || dut.r_count != 0) begin
         miscompares++;
         $display("FAIL rdr_state: got disc=%0d out=%0d cnt=%0d want 2/2/0", dut.r_discard,
                  dut.r_outstanding, dut.r_count);
      end
      vectors++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h104) begin
         miscompares++;
         $display("FAIL rdr_first_req: got valid=%b addr=%h want 1/104", imem_req_valid,
                  imem_req_addr);
      end
      n = 0;
      while (!id_valid && n < 20) begin
         tick();
         n++;
      end
      vectors++;
      if (id_valid !== 1'b1 || id_pc !== 32'h104 || id_instr !== instr_of(32'h104)) begin
         miscompares++;
         $display("FAIL rdr_head: got valid=%b pc=%h instr=%h want 1/104/%h", id_valid, id_pc,
                  id_instr, instr_of(32'h104));
      end
      vectors++;
      if (pop_pc.size() != 0 || dut.r_discard != 0) begin
         miscompares++;
         $display("FAIL rdr_stale: got pops=%0d disc=%0d want 0/0", pop_pc.size(), dut.r_discard);
      end
      vectors++;
      if (req_log.size() < 3 || req_log[0] !== 32'h20 || req_log[1] !== 32'h24
          || req_log[2] !== 32'h104) begin
         miscompares++;
         $display("FAIL rdr_reqs: got size=%0d want 20,24,104 sequence", req_log.size());
      end
   endtask

   task automatic test_redirect_collide();
      int n;
      lat = 2; imem_req_ready = 1'b1; id_ready = 1'b1;
      do_reset();
      repeat (3) tick();
      vectors++;
      if (id_valid !== 1'b1 || id_pc !== 32'h0 || imem_resp_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL col_setup: got valid=%b pc=%h resp=%b want 1/0/1", id_valid, id_pc,
                  imem_resp_valid);
      end
      redirect = 1'b1; redirect_pc = 32'h203;
      #1;
      vectors++;
      if (imem_req_valid !== 1'b0) begin
         miscompares++; $display("FAIL col_no_req: got %b want 0", imem_req_valid);
      end
      tick();
      redirect = 1'b0;
      #1;
      vectors++;
      if (dut.r_count != 0 || dut.r_discard != 1 || dut.r_outstanding != 1) begin
         miscompares++;
         $display("FAIL col_state: got cnt=%0d disc=%0d out=%0d want 0/1/1", dut.r_count,
                  dut.r_discard, dut.r_outstanding);
      end
      vectors++;
      if (id_valid !== 1'b0 || id_pc !== 32'h200) begin
         miscompares++;
         $display("FAIL col_head: got valid=%b pc=%h want 0/200", id_valid, id_pc);
      end
      n = 0;
      while (!id_valid && n < 20) begin
         tick();
         n++;
      end
      vectors++;
      if (id_valid !== 1'b1 || id_pc !== 32'h200 || id_instr !== instr_of(32'h200)) begin
         miscompares++;
         $display("FAIL col_after: got valid=%b pc=%h instr=%h want 1/200/%h", id_valid, id_pc,
                  id_instr, instr_of(32'h200));
      end
   endtask

   task automatic test_backpressure();
      lat = 1; imem_req_ready = 1'b0; id_ready = 1'b1;
      do_reset();
      redirect = 1'b1; redirect_pc = 32'h40;
      tick();
      redirect = 1'b0;
      #1;
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40 || dut.r_outstanding != 0) begin
            miscompares++;
            $display("FAIL bp_hold[%0d]: got valid=%b addr=%h out=%0d want 1/40/0", i,
                     imem_req_valid, imem_req_addr, dut.r_outstanding);
         end
         tick();
      end
      imem_req_ready = 1'b1;
      #1;
      vectors++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin
         miscompares++;
         $display("FAIL bp_accept: got valid=%b addr=%h want 1/40", imem_req_valid, imem_req_addr);
      end
      tick();
      #1;
      vectors++;
      if (imem_req_addr !== 32'h44 || dut.r_outstanding != 1 || req_log.size() != 1) begin
         miscompares++;
         $display("FAIL bp_next: got addr=%h out=%0d reqs=%0d want 44/1/1", imem_req_addr,
                  dut.r_outstanding, req_log.size());
      end
   endtask

   task automatic test_back_to_back();
      int n;
      lat = 3; imem_req_ready = 1'b1; id_ready = 1'b1;
      do_reset();
      tick();
      tick();
      redirect = 1'b1; redirect_pc = 32'h300;
      tick();
      #1;
      vectors++;
      if (dut.r_discard != 2 || dut.r_outstanding != 2) begin
         miscompares++;
         $display("FAIL b2b_first: got disc=%0d out=%0d want 2/2", dut.r_discard,
                  dut.r_outstanding);
      end
      redirect_pc = 32'h400;
      tick();
      redirect = 1'b0;
      #1;
      vectors++;
      if (dut.r_discard != 1 || dut.r_outstanding != 1 || dut.r_count != 0) begin
         miscompares++;
         $display("FAIL b2b_second: got disc=%0d out=%0d cnt=%0d want 1/1/0", dut.r_discard,
                  dut.r_outstanding, dut.r_count);
      end
      n = 0;
      while (!id_valid && n < 20) begin
         tick();
         n++;
      end
      vectors++;
      if (id_valid !== 1'b1 || id_pc !== 32'h400 || id_instr !== instr_of(32'h400)) begin
         miscompares++;
         $display("FAIL b2b_head: got valid=%b pc=%h instr=%h want 1/400/%h", id_valid, id_pc,
                  id_instr, instr_of(32'h400));
      end
      vectors++;
      if (req_log.size() < 3 || req_log[2] !== 32'h400) begin
         miscompares++;
         $display("FAIL b2b_req: got size=%0d want third request 400", req_log.size());
      end
   endtask

   task automatic test_reset_mid();
      lat = 1; imem_req_ready = 1'b1; id_ready = 1'b0;
      do_reset();
      repeat (4) tick();
      vectors++;
      if (dut.r_count != 3 || dut.r_outstanding != 1) begin
         miscompares++;
         $display("FAIL rst_mid_setup: got cnt=%0d out=%0d want 3/1", dut.r_count,
                  dut.r_outstanding);
      end
      reset = 1'b1;
      #1;
      vectors++;
      if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 || id_instr !== NOP || id_pc !== 32'h0) begin
         miscompares++;
         $display("FAIL rst_mid_during: got rv=%b iv=%b instr=%h pc=%h want 0/0/%h/0",
                  imem_req_valid, id_valid, id_instr, id_pc, NOP);
      end
      tick();
      reset = 1'b0;
      #1;
      clear_logs();
      vectors++;
      if (id_valid !== 1'b0 || id_instr !== NOP || id_pc !== 32'h0 || dut.r_count != 0
          || dut.r_outstanding != 0) begin
         miscompares++;
         $display("FAIL rst_mid_after: got iv=%b instr=%h pc=%h cnt=%0d out=%0d want 0/%h/0/0/0",
                  id_valid, id_instr, id_pc, dut.r_count, dut.r_outstanding, NOP);
      end
      vectors++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
         miscompares++;
         $display("FAIL rst_mid_req: got valid=%b addr=%h want 1/0", imem_req_valid,
                  imem_req_addr);
      end
      id_ready = 1'b1;
      repeat (4) tick();
      vectors++;
      if (pop_pc.size() < 1 || pop_pc[0] !== 32'h0 || pop_ins[0] !== instr_of(32'h0)) begin
         miscompares++;
         $display("FAIL rst_mid_restart: got pops=%0d want first pop pc 0", pop_pc.size());
      end
   endtask

   initial begin
      vectors         = 0;
      miscompares     = 0;
      cyc             = 0;
      lat             = 1;
      reset           = 1'b1;
      redirect        = 1'b0;
      redirect_pc     = 32'h0;
      imem_req_ready  = 1'b1;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      id_ready        = 1'b1;

      test_reset();
      test_sequential();
      test_stall();
      test_redirect_inflight();
      test_redirect_collide();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
